icache_fetch_controller: RTL and testbench

//  Direct-mapped instruction cache and controller between the pipeline fetch stage and the

---
 rtl/icache_fetch_controller.sv | 129 ++++++++++++
 tb/tb_icache_fetch_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_controller.sv
// Direct-mapped, read-only instruction cache with a single-line refill sequencer.
// Hits return data combinationally; misses stall fetch for MEM_LATENCY wait cycles.
module icache_fetch_controller #(
    parameter int LINES       = 8,
    parameter int IDX_BITS    = 3,
    parameter int MEM_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fetch_req_i,
    input  logic [31:0]      pc_address_i,
    input  logic             flush_i,
    output logic [31:0]      instruction_out_o,
    output logic             stall_o,
    output logic [31:0]      mem_address_o,
    input  logic [31:0]      mem_data_in_i,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] miss_count_o,
    output logic             state_o
);
    // Handshake: stall_o=0 means instruction_out_o is valid this cycle and the PC may advance;
    // stall_o=1 means the fetch stage must hold pc_address_i and re-present it next cycle.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;
    localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int TAG_W = 30 - IDX_BITS;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    logic                state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [31:0]         data_q [LINES];

    logic                fill;
    logic                stall_c;
    logic [31:0]         instr_c;
    logic [IDX_BITS-1:0] idx, fill_idx;
    logic [TAG_W-1:0]    tag, fill_tag;
    logic                hit;
    logic                unused_low_bits;

    assign idx      = pc_address_i[IDX_BITS+1:2];
    assign tag      = pc_address_i[31:IDX_BITS+2];
    assign fill_idx = mem_addr_q[IDX_BITS+1:2];
    assign fill_tag = mem_addr_q[31:IDX_BITS+2];
    assign hit      = fetch_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign unused_low_bits = ^pc_address_i[1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        valid_d    = valid_q;
        fill       = 1'b0;
        stall_c    = 1'b0;
        instr_c    = 32'h0;
        case (state_q)
            ST_IDLE: begin
                // Flush takes priority over lookup and suppresses counting.
                if (flush_i) begin
                    stall_c = 1'b1;
                    valid_d = '0;
                end else if (hit) begin
                    instr_c = data_q[idx];
                    if (hit_q != '1) hit_d = hit_q + 1'b1;
                end else if (fetch_req_i) begin
                    stall_c    = 1'b1;
                    mem_addr_d = pc_address_i;
                    cnt_d      = CNT_INIT;
                    state_d    = ST_WAIT;
                    if (miss_q != '1) miss_d = miss_q + 1'b1;
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (flush_i) begin
                    valid_d = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    fill              = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            valid_q    <= valid_d;
        end
    end

    // Tag/data storage needs no reset: the valid bits gate every read.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data_in_i;
        end
    end

    assign stall_o           = rst_ni & stall_c;
    assign instruction_out_o = rst_ni ? instr_c : 32'h0;
    assign mem_address_o     = mem_addr_q;
    assign hit_count_o       = hit_q;
    assign miss_count_o      = miss_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_icache_fetch_controller.sv
// Bench for icache_fetch_controller: a word-address cache model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_icache_fetch_controller;
    localparam int LAT   = 3;
    localparam int LINES = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc = 32'h0;

    logic [31:0] instr, maddr, mdata, instr_s, maddr_s, mdata_s;
    logic        stall, stall_s, st, st_s;
    logic [15:0] hc, mc;
    logic [1:0]  hc_s, mc_s;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: each line remembers the full byte address it was filled from.
    bit          m_valid [LINES];
    logic [31:0] m_line_addr [LINES];
    int          m_left = -1;
    logic [31:0] m_maddr = 32'h0;
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign mdata   = mem_fn(maddr);
    assign mdata_s = mem_fn(maddr_s);

    always #5 clk = ~clk;

    icache_fetch_controller #(.LINES(8), .IDX_BITS(3), .MEM_LATENCY(LAT), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .fetch_req_i(req), .pc_address_i(pc), .flush_i(flush),
        .instruction_out_o(instr), .stall_o(stall), .mem_address_o(maddr),
        .mem_data_in_i(mdata), .hit_count_o(hc), .miss_count_o(mc), .state_o(st)
    );

    icache_fetch_controller #(.LINES(8), .IDX_BITS(3), .MEM_LATENCY(LAT), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .fetch_req_i(req), .pc_address_i(pc), .flush_i(flush),
        .instruction_out_o(instr_s), .stall_o(stall_s), .mem_address_o(maddr_s),
        .mem_data_in_i(mdata_s), .hit_count_o(hc_s), .miss_count_o(mc_s), .state_o(st_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        int i;
        i = int'(pc[4:2]);
        return req && m_valid[i] && (m_line_addr[i][31:2] == pc[31:2]);
    endfunction

    // Model state advance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_left = -1; m_maddr = 32'h0; m_hits = 0; m_misses = 0;
        end else if (m_left >= 0) begin
            if (flush) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_left = -1;
            end else if (m_left == 0) begin
                m_valid[m_maddr[4:2]] = 1'b1;
                m_line_addr[m_maddr[4:2]] = m_maddr;
                m_left = -1;
            end else begin
                m_left--;
            end
        end else if (flush) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else if (req) begin
            if (m_hit()) m_hits++;
            else begin
                m_maddr = pc; m_left = LAT - 1; m_misses++;
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_stall;
            logic [31:0] e_instr;
            e_stall = 1'b0;
            e_instr = 32'h0;
            if (rst_n) begin
                if (m_left >= 0 || flush) e_stall = 1'b1;
                else if (req) begin
                    if (m_hit()) e_instr = mem_fn(m_line_addr[pc[4:2]]);
                    else e_stall = 1'b1;
                end
            end
            chk("stall", 32'(stall), 32'(e_stall));
            chk("instr", instr, e_instr);
            chk("maddr", maddr, m_maddr);
            chk("state", 32'(st), 32'(m_left >= 0));
            chk("hits", 32'(hc), (m_hits > 65535) ? 32'd65535 : 32'(m_hits));
            chk("misses", 32'(mc), (m_misses > 65535) ? 32'd65535 : 32'(m_misses));
            chk("stall_s", 32'(stall_s), 32'(e_stall));
            chk("instr_s", instr_s, e_instr);
            chk("hits_sat", 32'(hc_s), (m_hits > 3) ? 32'd3 : 32'(m_hits));
            chk("misses_sat", 32'(mc_s), (m_misses > 3) ? 32'd3 : 32'(m_misses));
        end
    end

    task automatic set_in(input logic r, input logic [31:0] p, input logic f);
        req = r; pc = p; flush = f;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fill(input logic [31:0] p);
        for (int i = 0; i < LAT; i++) begin
            set_in(1'b1, p, 1'b0);
            tick();
        end
    endtask

    initial begin
        #1;
        chk_en = 1'b1;
        // Reset with a request pending: outputs stay quiet.
        set_in(1'b1, 32'd16, 1'b0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_hits", 32'(hc), 32'd0);
        tick();
        rst_n = 1'b1;

        // Cold miss on 16: four stall cycles, then a hit.
        set_in(1'b1, 32'd16, 1'b0);
        chk("cold_stall0", 32'(stall), 32'd1);
        tick();
        for (int i = 0; i < LAT; i++) begin
            set_in(1'b1, 32'd16, 1'b0);
            chk("cold_stall_wait", 32'(stall), 32'd1);
            chk("cold_maddr", maddr, 32'd16);
            tick();
        end
        set_in(1'b1, 32'd16, 1'b0);
        chk("cold_hit_stall", 32'(stall), 32'd0);
        chk("cold_hit_instr", instr, 32'hDEAD_0010);
        chk("cold_misses", 32'(mc), 32'd1);
        tick();
        chk("cold_hits", 32'(hc), 32'd1);

        // Repeated fetches hit every cycle.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'd16, 1'b0);
            chk("rep_stall", 32'(stall), 32'd0);
            tick();
        end
        chk("rep_hits", 32'(hc), 32'd4);
        chk("rep_hits_sat", 32'(hc_s), 32'd3);
        chk("rep_maddr", maddr, 32'd16);

        // Conflict: 48 shares index 4 with 16.
        set_in(1'b1, 32'd48, 1'b0);
        chk("conf_48_miss", 32'(stall), 32'd1);
        tick();
        wait_fill(32'd48);
        set_in(1'b1, 32'd48, 1'b0);
        chk("conf_48_instr", instr, 32'hDEAD_0030);
        tick();
        set_in(1'b1, 32'd16, 1'b0);
        chk("conf_16_miss", 32'(stall), 32'd1);
        tick();
        chk("conf_misses", 32'(mc), 32'd3);
        wait_fill(32'd16);
        set_in(1'b1, 32'd16, 1'b0);
        tick();

        // Flush with a cached request: stall, no hit counted, then a miss.
        set_in(1'b1, 32'd16, 1'b1);
        chk("flush_stall", 32'(stall), 32'd1);
        tick();
        chk("flush_hits", 32'(hc), 32'd6);
        set_in(1'b1, 32'd16, 1'b0);
        chk("flush_remiss", 32'(stall), 32'd1);
        tick();
        wait_fill(32'd16);
        set_in(1'b1, 32'd16, 1'b0);
        tick();

        // Flush during the second WAIT cycle aborts the fill of line 5.
        set_in(1'b1, 32'd20, 1'b0);
        tick();
        set_in(1'b1, 32'd20, 1'b0);
        tick();
        set_in(1'b1, 32'd20, 1'b1);
        tick();
        set_in(1'b1, 32'd20, 1'b0);
        chk("wflush_idle", 32'(st), 32'd0);
        chk("wflush_remiss", 32'(stall), 32'd1);
        tick();
        chk("wflush_misses", 32'(mc), 32'd6);
        wait_fill(32'd20);
        set_in(1'b1, 32'd20, 1'b0);
        tick();

        // Reset in the middle of a miss.
        set_in(1'b1, 32'd24, 1'b0);
        tick();
        set_in(1'b1, 32'd24, 1'b0);
        tick();
        rst_n = 1'b0;
        #2;
        chk("wrst_stall", 32'(stall), 32'd0);
        chk("wrst_hits", 32'(hc), 32'd0);
        chk("wrst_misses", 32'(mc), 32'd0);
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 32'd16, 1'b0);
        chk("wrst_cold", 32'(stall), 32'd1);
        tick();
        wait_fill(32'd16);

        // Randomized traffic over four tags per index.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            p = pc;
            if ($urandom_range(0, 3) != 0)
                p = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
                    | 32'($urandom_range(0, 3));
            set_in(1'($urandom_range(0, 9) < 8), p, 1'($urandom_range(0, 29) == 0));
            tick();
        end

        req = 1'b0; flush = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
